// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives data-memory accesses over a req/ack handshake,
// stalls upstream while an access is in flight and forms the write-back bundle.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] nextPC,
   input  logic [31:0] opB,
   input  logic [4:0]  destReg,
   input  logic [31:0] aluResult,
   input  logic        PCtoReg,
   input  logic        RegWrite,
   input  logic        MemToReg,
   input  logic        MemWrite,
   input  logic        loadSign,
   input  logic [1:0]  DSize,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [0:3]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_destReg,
   output logic        wb_RegWrite,
   output logic        misalign,
   output logic        bus_err
);
   // state   | meaning
   // S_IDLE  | no access in flight; a valid mem op launches a request
   // S_WAIT  | request outstanding, waiting for dmem_ack or timeout
   // S_DONE  | access finished; pipeline advances for exactly one cycle
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [0:3]  be_q, be_d;
   logic [31:0] load_data_q, load_data_d;
   logic        bus_err_q, bus_err_d;

   logic        mem_op, misaligned, launch, timed_out;
   logic [1:0]  off;
   logic [31:0] st_wdata, ld_ext;
   logic [0:3]  st_be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign off        = aluResult[1:0];
   assign mem_op     = MemToReg | MemWrite;
   assign misaligned = mem_op & (((DSize == 2'b01) & off[0]) |
                                 (DSize[1] & (off != 2'b00)));
   assign launch     = mem_op & ~misaligned;
   assign timed_out  = (cnt_q == CW'(TIMEOUT - 1));

   // Lanes are numbered big-endian: byte offset 0 is bits [31:24].
   always_comb begin
      st_wdata = opB;
      st_be    = 4'b1111;
      case (DSize)
         2'b00: begin
            st_wdata = {4{opB[7:0]}};
            st_be    = 4'b1000 >> off;
         end
         2'b01: begin
            st_wdata = {2{opB[15:0]}};
            st_be    = off[1] ? 4'b0011 : 4'b1100;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = dmem_rdata[{~off, 3'b000} +: 8];
      ld_half = off[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
      case (DSize)
         2'b00:   ld_ext = {{24{loadSign & ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = {{16{loadSign & ld_half[15]}}, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         load_data_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         load_data_q <= load_data_d;
         bus_err_q   <= bus_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (launch) state_d = S_WAIT;
         S_WAIT:  if (dmem_ack || timed_out) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      load_data_d = load_data_q;
      bus_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_d = launch;
            if (launch) begin
               we_d        = MemWrite;
               addr_d      = {aluResult[31:2], 2'b00};
               wdata_d     = st_wdata;
               be_d        = st_be;
               cnt_d       = '0;
               load_data_d = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (dmem_ack) begin
               req_d       = 1'b0;
               load_data_d = ld_ext;
            end else if (timed_out) begin
               req_d       = 1'b0;
               load_data_d = '0;
               bus_err_d   = 1'b1;
            end
         end
         default: req_d = 1'b0;
      endcase
   end

   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_wdata  = wdata_q;
   assign dmem_be     = be_q;
   assign bus_err     = bus_err_q;
   assign misalign    = misaligned;
   assign mem_stall   = ((state_q == S_IDLE) & launch) | (state_q == S_WAIT);
   assign wb_data     = PCtoReg ? nextPC : (MemToReg ? load_data_q : aluResult);
   assign wb_destReg  = destReg;
   assign wb_RegWrite = RegWrite & ~misaligned & ~bus_err_q;
endmodule
